// File: rtl/mux_pkg.sv
// Shared definitions for the 8-to-1 single-bit multiplexer slice.
//   MUX8_N_IN   : number of data inputs (8)
//   MUX8_SEL_W  : select width (3)
//   mux8_sel_t  : select code type
//   mux8_data_t : data bus type
package mux_pkg;

    localparam int MUX8_N_IN  = 8;
    localparam int MUX8_SEL_W = 3;

    typedef logic [MUX8_SEL_W-1:0] mux8_sel_t;
    typedef logic [MUX8_N_IN-1:0]  mux8_data_t;

endpackage : mux_pkg

// File: rtl/mux_8x1_comb.sv
// Purely combinational 8-to-1 bit selector.
// Optional feature macro: MUX_8X1_SEL_ERR_EN (adds x_err output).
// Ports:
//   I     in  8  data inputs, I[k] is input k
//   sel   in  3  binary select
//   y     out 1  selected bit, RST_VAL when sel is not a valid code
//   x_err out 1  (MUX_8X1_SEL_ERR_EN only) sel or the selected bit is X/Z
module mux_8x1_comb
    import mux_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  mux8_data_t I,
    input  mux8_sel_t  sel,
    output logic       y
`ifdef MUX_8X1_SEL_ERR_EN
    ,
    output logic       x_err
`endif
);

    // A case select (rather than an and-or tree) keeps unselected X bits
    // from reaching y. An X/Z select only ever matches the default arm,
    // which gives a defined value in simulation and folds away in synthesis.
    logic sel_unknown;

    always_comb begin
        y           = RST_VAL;
        sel_unknown = 1'b0;
        case (sel)
            3'd0:    y = I[0];
            3'd1:    y = I[1];
            3'd2:    y = I[2];
            3'd3:    y = I[3];
            3'd4:    y = I[4];
            3'd5:    y = I[5];
            3'd6:    y = I[6];
            3'd7:    y = I[7];
            default: sel_unknown = 1'b1;
        endcase
    end

`ifdef MUX_8X1_SEL_ERR_EN
    // The selected bit is unknown when it matches neither 0 nor 1.
    logic data_unknown;

    always_comb begin
        data_unknown = 1'b0;
        case (y)
            1'b0, 1'b1: data_unknown = 1'b0;
            default:    data_unknown = 1'b1;
        endcase
        x_err = sel_unknown | data_unknown;
    end
`else
    // Select-unknown status is only consumed by the error flag.
    logic unused_sel_unknown;
    assign unused_sel_unknown = sel_unknown;
`endif

endmodule : mux_8x1_comb

// File: rtl/mux_8x1.sv
// 8-to-1 single-bit multiplexer with registered output and load enable.
// Optional feature macro: MUX_8X1_SEL_ERR_EN (adds registered sel_err).
// Ports:
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset, priority over en
//   en      in  1  load enable; mux_op updates only when high
//   mux_op  out 1  registered I[sel], RST_VAL on reset
//   I       in  8  data inputs, I[k] is input k
//   sel     in  3  binary select
//   sel_err out 1  (MUX_8X1_SEL_ERR_EN only) sel or I[sel] was X/Z on
//                  the last enabled edge
module mux_8x1
    import mux_pkg::*;
#(
    parameter int   N_IN    = 8,
    parameter logic RST_VAL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    mux_op,
    input  logic [N_IN-1:0]         I,
    input  logic [$clog2(N_IN)-1:0] sel
`ifdef MUX_8X1_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic sel_bit;

`ifdef MUX_8X1_SEL_ERR_EN
    logic x_err;

    mux_8x1_comb #(
        .RST_VAL (RST_VAL)
    ) u_comb (
        .I     (I),
        .sel   (sel),
        .y     (sel_bit),
        .x_err (x_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (en) begin
            sel_err <= x_err;
        end
    end
`else
    mux_8x1_comb #(
        .RST_VAL (RST_VAL)
    ) u_comb (
        .I   (I),
        .sel (sel),
        .y   (sel_bit)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_op <= RST_VAL;
        end else if (en) begin
            mux_op <= sel_bit;
        end
    end

endmodule : mux_8x1

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: directed vectors, a reference model of
// the registered select, and a per-cycle compare on the falling edge.
// Optional feature macro: MUX_8X1_SEL_ERR_EN (checks sel_err as well).
module tb_mux_8x1;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mux_op;
    logic [7:0] I;
    logic [2:0] sel;
`ifdef MUX_8X1_SEL_ERR_EN
    logic       sel_err;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    mux_8x1 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mux_op  (mux_op),
        .I       (I),
        .sel     (sel)
`ifdef MUX_8X1_SEL_ERR_EN
        ,
        .sel_err (sel_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an enabled edge captures bit number sel of I; an
    // unknown select yields 0. The error flag marks an unknown select or an
    // unknown selected bit.
    function automatic logic pick(input logic [7:0] d, input logic [2:0] s);
        if ($isunknown(s)) return 1'b0;
        return d[s];
    endfunction

    function automatic logic bad(input logic [7:0] d, input logic [2:0] s);
        if ($isunknown(s)) return 1'b1;
        return $isunknown(d[s]) ? 1'b1 : 1'b0;
    endfunction

    logic exp_op;
    logic exp_err;
    logic armed = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_op  = 1'b0;
            exp_err = 1'b0;
            armed   = 1'b1;
        end else if (en === 1'b1) begin
            exp_op  = pick(I, sel);
            exp_err = bad(I, sel);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            check("model_mux_op", mux_op, exp_op);
`ifdef MUX_8X1_SEL_ERR_EN
            check("model_sel_err", sel_err, exp_err);
`endif
        end
    end

    // Drive a vector 1 time unit after an edge, then return 1 unit after
    // the edge that captured it.
    task automatic apply(input logic r, input logic e, input logic [7:0] d,
                         input logic [2:0] s);
        rst = r;
        en  = e;
        I   = d;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] walk_seq;

        rst = 1'b1;
        en  = 1'b0;
        I   = 8'h00;
        sel = 3'b000;
        #1;

        // Reset for two edges.
        apply(1'b1, 1'b0, 8'h00, 3'b000);
        apply(1'b1, 1'b0, 8'h00, 3'b000);
        check("reset_value", mux_op, 1'b0);
`ifdef MUX_8X1_SEL_ERR_EN
        check("reset_sel_err", sel_err, 1'b0);
`endif

        // Select 0 with all other bits unknown.
        apply(1'b0, 1'b1, 8'bxxxxxxx1, 3'b000);
        check("sel0_x_isolation", mux_op, 1'b1);

        // Walking select over 1010_0110: bit k appears one edge after sel=k.
        walk_seq = 8'b1010_0110;
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b1, 8'b1010_0110, 3'(k));
            check("walk_select", mux_op, walk_seq[k]);
        end

        // Enable hold.
        apply(1'b0, 1'b1, 8'h01, 3'b000);
        check("hold_load", mux_op, 1'b1);
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 8'h00, 3'b000);
            check("hold_en_low", mux_op, 1'b1);
        end
        apply(1'b0, 1'b1, 8'h00, 3'b000);
        check("hold_release", mux_op, 1'b0);

        // Reset priority; a mid-cycle reset waits for the edge.
        apply(1'b0, 1'b1, 8'hFF, 3'b101);
        check("pre_reset_load", mux_op, 1'b1);
        rst = 1'b1;
        #3;
        check("reset_between_edges", mux_op, 1'b1);
        @(posedge clk);
        #1;
        check("reset_priority", mux_op, 1'b0);
        apply(1'b0, 1'b1, 8'hFF, 3'b101);
        check("reset_resume", mux_op, 1'b1);

        // X isolation on a data bit and an unknown select.
        apply(1'b0, 1'b1, 8'bx1xxxxxx, 3'b110);
        check("x_isolation_sel6", mux_op, 1'b1);
        apply(1'b0, 1'b1, 8'bx1xxxxxx, 3'bx1x);

        // Unknown selected data bit, then a clean selection.
        apply(1'b0, 1'b1, 8'bxxxxxxx0, 3'b011);
        apply(1'b0, 1'b1, 8'bxxxxxxx0, 3'b000);
        check("clean_after_err", mux_op, 1'b0);
`ifdef MUX_8X1_SEL_ERR_EN
        check("sel_err_cleared", sel_err, 1'b0);
`endif

        // Mixed directed vectors with enable toggling.
        apply(1'b0, 1'b1, 8'h5A, 3'b001);
        check("mixed_5a_s1", mux_op, 1'b1);
        apply(1'b0, 1'b1, 8'h5A, 3'b010);
        check("mixed_5a_s2", mux_op, 1'b0);
        apply(1'b0, 1'b0, 8'hA5, 3'b010);
        check("mixed_hold", mux_op, 1'b0);
        apply(1'b0, 1'b1, 8'hA5, 3'b111);
        check("mixed_a5_s7", mux_op, 1'b1);
        apply(1'b0, 1'b1, 8'h80, 3'b110);
        check("mixed_80_s6", mux_op, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_mux_8x1
